frame_upscaler: RTL and testbench
=================================

Name: frame_upscaler

Overview:
- Produces the raster pixel stream for `ili9341_controller`, replacing ad-hoc scaling logic in the top level.
- Reads a low-resolution RGB565 source image (default 80x80) from a synchronous ROM/BRAM.
- Replicates each source pixel SCALE times horizontally and vertically, giving a 240x240 stream in row-major order.
- Also supports a solid-colour frame mode (no memory reads) for mood/status screens.
- Output uses a valid/ready handshake, consumed by the pixel-capture logic that feeds the SPI controller.

Parameters:
- SRC_W, 80, source image width in pixels
- SRC_H, 80, source image height in pixels
- SCALE, 3, integer replication factor per axis (>=1)
- PIXEL_SIZE, 16, bits per pixel (RGB565)
- ADDR_W, $clog2(SRC_W*SRC_H), source memory address width

Ports:
- clk  in  1  system clock (same domain as the controller clock)
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle request to emit one frame; honoured only when busy=0
- solid_en  in  1  sampled at accepted start; 1 = emit solid_color for the whole frame
- solid_color  in  PIXEL_SIZE  colour for solid mode, sampled at accepted start
- mem_en  out  1  source memory read enable
- mem_addr  out  ADDR_W  source memory address
- mem_rdata  in  PIXEL_SIZE  read data, valid exactly 1 cycle after mem_en
- pix_data  out  PIXEL_SIZE  output pixel
- pix_valid  out  1  pix_data is valid
- pix_ready  in  1  consumer accepts pixel when pix_valid & pix_ready
- pix_last  out  1  high with the final pixel of the frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, all counters 0, FSM=IDLE. Applies mid-frame too; the partial frame is abandoned with no frame_done.
- Counters:
  - src_x 0..SRC_W-1, rep_x 0..SCALE-1
  - src_y 0..SRC_H-1, rep_y 0..SCALE-1
  - row_base = src_y*SRC_W, maintained by adding SRC_W (no multiplier)
  - mem_addr = row_base + src_x
- FSM:
  - IDLE: busy=0.
    - start=1 → latch solid_en and solid_color, clear counters, busy=1.
    - Go to READ, or to EMIT if solid mode.
  - READ: mem_en=1 for one cycle with mem_addr; go to LATCH.
  - LATCH: capture mem_rdata into the pixel register; go to EMIT.
  - EMIT: pix_valid=1; pix_data is the pixel register (or solid_color).
    - While pix_ready=0: hold data, valid and last stable.
    - On handshake, rep_x++.
    - When rep_x wraps, src_x++ and go to READ (solid mode: stay in EMIT).
    - When src_x wraps: rep_y++; src_x=0.
    - When rep_y wraps: src_y++; row_base += SRC_W.
    - After the handshake with pix_last=1 → DONE.
  - DONE: frame_done=1 for one cycle, busy=0, pix_valid=0; go to IDLE.
- Ordering:
  - Rows with the same src_y re-read the same addresses (no line buffer).
  - Output row r, column c = source[(r/SCALE)*SRC_W + c/SCALE].
- Throughput:
  - Image mode: 2 bubble cycles per SCALE output pixels.
  - Solid mode: 1 pixel/cycle when ready is held high.
- pix_last = 1 exactly when src_x=SRC_W-1, src_y=SRC_H-1, rep_x=SCALE-1, rep_y=SCALE-1 in EMIT.
- Pixels per frame: SRC_W*SRC_H*SCALE*SCALE (57600 at defaults). Last address SRC_W*SRC_H-1 (6399 at defaults); no wrap past it.
- start while busy=1: ignored, not queued.
- start in the same cycle as a DONE exit: ignored; accepted in IDLE only.
- mem_en=0 in every state except READ. mem_addr holds its last value elsewhere.
- SCALE=1: every handshake is followed by READ.

Decomposition:
- `ili9341_pkg` holds:
  - RGB565 colour constants: BLACK 0000, RED F800, PURPLE 780F, CYAN 07FF, BLUE 001F
  - default SRC_W/SRC_H/SCALE
  - the FSM state enum (IDLE, READ, LATCH, EMIT, DONE)
- One sub-module, `scale_raster_counter`:
  - holds the four nested wrap counters plus row_base
  - inputs: advance, clear
  - outputs: addr, new_src_pixel, last
- `frame_upscaler` keeps the FSM, the pixel register and the handshake.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with start=1 → pix_valid, busy, mem_en, frame_done, pix_last all 0; mem_addr=0.
2. SRC_W=SRC_H=4, SCALE=3, ROM[i]=i, pix_ready=1, start pulse → 144 pixels.
   - Outputs 0-2 = 0000 and 3-5 = 0001.
   - Outputs 12, 24 = 0000; output 36 = 0004.
   - pix_last on output 143 (=000F).
   - frame_done one cycle after; busy drops.
3. Backpressure: same setup, pix_ready random 50% → identical 144-value sequence. pix_data and pix_last never change while pix_valid & !pix_ready.
4. Solid mode: defaults, solid_en=1, solid_color=F800, ready=1 → 57600 consecutive cycles of F800 and mem_en never 1. Then frame_done, then idle.
5. Defaults, image mode → last read address 6399, pix_last on handshake 57600. A start pulse at pixel 1000 changes nothing.
6. rst=0 at pixel 500, then start → pix_valid drops next cycle with no frame_done. New frame begins at address 0 with output 0 = ROM[0].

Source files
------------

// File: rtl/frame_upscaler_pkg.sv
// frame_upscaler_pkg: shared colours, default geometry and FSM states
package frame_upscaler_pkg;
   localparam logic [15:0] BLACK  = 16'h0000;
   localparam logic [15:0] RED    = 16'hF800;
   localparam logic [15:0] PURPLE = 16'h780F;
   localparam logic [15:0] CYAN   = 16'h07FF;
   localparam logic [15:0] BLUE   = 16'h001F;
   localparam int DEF_SRC_W = 80;
   localparam int DEF_SRC_H = 80;
   localparam int DEF_SCALE = 3;
   typedef enum logic [2:0] {IDLE, READ, LATCH, EMIT, DONE} state_t;
endpackage

// File: rtl/frame_upscaler_if.sv
// frame_upscaler_if: valid/ready pixel stream toward the display capture logic
interface frame_upscaler_if #(parameter int PIXEL_SIZE = 16) ();
   logic [PIXEL_SIZE-1:0] pix_data;
   logic pix_valid;
   logic pix_ready;
   logic pix_last;
   modport master (output pix_data, pix_valid, pix_last, input pix_ready);
   modport slave (input pix_data, pix_valid, pix_last, output pix_ready);
endinterface

// File: rtl/frame_upscaler_counter.sv
// scale_raster_counter: nested source/replication counters producing the source address
module scale_raster_counter #(
   parameter int SRC_W = 80,
   parameter int SRC_H = 80,
   parameter int SCALE = 3,
   parameter int ADDR_W = $clog2(SRC_W * SRC_H)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic advance,
   output logic [ADDR_W-1:0] addr,
   output logic new_src_pixel,
   output logic last
);
   localparam int XW = $clog2(SRC_W + 1);
   localparam int YW = $clog2(SRC_H + 1);
   localparam int RW = $clog2(SCALE + 1);
   logic [XW-1:0] src_x;
   logic [YW-1:0] src_y;
   logic [RW-1:0] rep_x, rep_y;
   logic [ADDR_W-1:0] row_base;
   logic x_end, y_end, ry_end;
   assign new_src_pixel = rep_x == RW'(SCALE - 1);
   assign x_end = src_x == XW'(SRC_W - 1);
   assign ry_end = rep_y == RW'(SCALE - 1);
   assign y_end = src_y == YW'(SRC_H - 1);
   assign last = new_src_pixel && x_end && ry_end && y_end;
   assign addr = row_base + ADDR_W'(src_x);
   // step the raster; the caller never advances past the last pixel so the address stays put after a frame
   always_ff @(posedge clk)
      if (!rst || clear) begin
         src_x <= '0;
         src_y <= '0;
         rep_x <= '0;
         rep_y <= '0;
         row_base <= '0;
      end else if (advance) begin
         rep_x <= new_src_pixel ? '0 : rep_x + RW'(1);
         if (new_src_pixel) begin
            src_x <= x_end ? '0 : src_x + XW'(1);
            if (x_end) begin
               rep_y <= ry_end ? '0 : rep_y + RW'(1);
               if (ry_end) begin
                  src_y <= src_y + YW'(1);
                  row_base <= row_base + ADDR_W'(SRC_W);
               end
            end
         end
      end
endmodule

// File: rtl/frame_upscaler.sv
// frame_upscaler: replicates a low-res source image (or a solid colour) into a scaled raster stream
module frame_upscaler
   import frame_upscaler_pkg::*;
#(
   parameter int SRC_W = DEF_SRC_W,
   parameter int SRC_H = DEF_SRC_H,
   parameter int SCALE = DEF_SCALE,
   parameter int PIXEL_SIZE = 16,
   parameter int ADDR_W = $clog2(SRC_W * SRC_H)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic solid_en,
   input  logic [PIXEL_SIZE-1:0] solid_color,
   output logic mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIXEL_SIZE-1:0] mem_rdata,
   frame_upscaler_if.master px,
   output logic busy,
   output logic frame_done
);
   state_t state;
   logic solid, valid, last, new_src_pixel, advance, clear;
   logic [PIXEL_SIZE-1:0] pix_reg;
   assign clear = state == IDLE && start;
   assign advance = valid && px.pix_ready && !last;
   assign px.pix_data = pix_reg;
   assign px.pix_valid = valid;
   assign px.pix_last = valid && last;
   scale_raster_counter #(
      .SRC_W(SRC_W),
      .SRC_H(SRC_H),
      .SCALE(SCALE),
      .ADDR_W(ADDR_W)
   ) u_cnt (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .advance(advance),
      .addr(mem_addr),
      .new_src_pixel(new_src_pixel),
      .last(last)
   );
   // frame sequencing: read one source pixel, then hold it for SCALE handshakes
   always_ff @(posedge clk)
      if (!rst) begin
         state <= IDLE;
         solid <= 1'b0;
         pix_reg <= '0;
         valid <= 1'b0;
         mem_en <= 1'b0;
         busy <= 1'b0;
         frame_done <= 1'b0;
      end else
         case (state)
            IDLE: if (start) begin
               solid <= solid_en;
               pix_reg <= solid_color;
               busy <= 1'b1;
               valid <= solid_en;
               mem_en <= !solid_en;
               state <= solid_en ? EMIT : READ;
            end
            READ: begin
               mem_en <= 1'b0;
               state <= LATCH;
            end
            LATCH: begin
               pix_reg <= mem_rdata;
               valid <= 1'b1;
               state <= EMIT;
            end
            EMIT: if (px.pix_ready) begin
               if (last) begin
                  valid <= 1'b0;
                  busy <= 1'b0;
                  frame_done <= 1'b1;
                  state <= DONE;
               end else if (new_src_pixel && !solid) begin
                  valid <= 1'b0;
                  mem_en <= 1'b1;
                  state <= READ;
               end
            end
            DONE: begin
               frame_done <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_frame_upscaler.sv
// tb_frame_upscaler: directed checks of a 4x4/x3 instance plus a default-size instance in solid mode
module tb_frame_upscaler;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   logic s_start = 1'b0, s_solid_en = 1'b0;
   logic [15:0] s_solid_color = 16'h0;
   logic s_mem_en, s_busy, s_done;
   logic [3:0] s_mem_addr;
   logic [15:0] s_mem_rdata;
   frame_upscaler_if #(.PIXEL_SIZE(16)) s_px ();
   frame_upscaler #(.SRC_W(4), .SRC_H(4), .SCALE(3), .PIXEL_SIZE(16), .ADDR_W(4)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .solid_en(s_solid_en), .solid_color(s_solid_color),
      .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata), .px(s_px),
      .busy(s_busy), .frame_done(s_done)
   );
   always @(posedge clk) if (s_mem_en) s_mem_rdata <= {12'h000, s_mem_addr};
   logic d_start = 1'b0, d_solid_en = 1'b0;
   logic [15:0] d_solid_color = 16'h0;
   logic d_mem_en, d_busy, d_done;
   logic [12:0] d_mem_addr;
   logic [15:0] d_mem_rdata;
   frame_upscaler_if #(.PIXEL_SIZE(16)) d_px ();
   frame_upscaler dut_d (
      .clk(clk), .rst(rst), .start(d_start), .solid_en(d_solid_en), .solid_color(d_solid_color),
      .mem_en(d_mem_en), .mem_addr(d_mem_addr), .mem_rdata(d_mem_rdata), .px(d_px),
      .busy(d_busy), .frame_done(d_done)
   );
   always @(posedge clk) if (d_mem_en) d_mem_rdata <= {3'b000, d_mem_addr};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_small(input int n);
      return ((n / 12) / 3) * 4 + (n % 12) / 3;
   endfunction

   task automatic run_small(input bit rnd, input int start_at, input int abort_at);
      int n = 0, reads = 0, cyc = 0, first_addr = -1, last_addr = -1;
      bit stall = 0, poked = 0;
      logic [15:0] hold_d = '0;
      logic hold_l = 1'b0;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      check("start_busy", s_busy, 1);
      while (n < 144) begin
         if (cyc++ > 2000) begin
            check("frame_timeout", n, 144);
            return;
         end
         s_px.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) begin
            check("hold_valid", s_px.pix_valid, 1);
            check("hold_data", s_px.pix_data, hold_d);
            check("hold_last", s_px.pix_last, hold_l);
         end
         stall = s_px.pix_valid && !s_px.pix_ready;
         hold_d = s_px.pix_data;
         hold_l = s_px.pix_last;
         if (s_mem_en) begin
            if (first_addr < 0) first_addr = s_mem_addr;
            last_addr = s_mem_addr;
            reads++;
         end
         s_start = (n == start_at) && !poked;
         if (s_start) poked = 1;
         if (s_px.pix_valid && s_px.pix_ready) begin
            check("pix", s_px.pix_data, exp_small(n));
            check("last", s_px.pix_last, n == 143);
            n++;
         end
         if (n == abort_at) return;
         if (n < 144) begin
            @(posedge clk); #1;
         end
      end
      s_start = 1'b0;
      @(posedge clk); #1;
      check("done_pulse", s_done, 1);
      check("done_busy", s_busy, 0);
      check("done_valid", s_px.pix_valid, 0);
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      check("done_once", s_done, 0);
      check("start_at_done_ignored", s_busy, 0);
      check("first_addr", first_addr, 0);
      check("last_addr", last_addr, 15);
      check("reads", reads, 48);
      check("addr_hold", s_mem_addr, 15);
      check("mem_en_idle", s_mem_en, 0);
   endtask

   initial begin
      int n;
      int mem_seen;
      s_start = 1'b1;
      d_start = 1'b1;
      s_px.pix_ready = 1'b0;
      d_px.pix_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", s_px.pix_valid, 0);
      check("rst_busy", s_busy, 0);
      check("rst_mem_en", s_mem_en, 0);
      check("rst_done", s_done, 0);
      check("rst_last", s_px.pix_last, 0);
      check("rst_addr", s_mem_addr, 0);
      check("rst_d_all", {d_px.pix_valid, d_busy, d_mem_en, d_done, d_px.pix_last, d_mem_addr}, 0);
      s_start = 1'b0;
      d_start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      run_small(0, -1, -1);
      run_small(1, -1, -1);
      run_small(1, 60, -1);
      d_solid_en = 1'b1;
      d_solid_color = 16'hF800;
      d_px.pix_ready = 1'b1;
      d_start = 1'b1;
      @(posedge clk); #1;
      d_start = 1'b0;
      n = 0;
      mem_seen = 0;
      repeat (57600) begin
         check("solid_px", {d_px.pix_valid, d_px.pix_data}, {1'b1, 16'hF800});
         check("solid_last", d_px.pix_last, n == 57599);
         if (d_mem_en) mem_seen++;
         n++;
         @(posedge clk); #1;
      end
      check("solid_done", d_done, 1);
      check("solid_valid_off", d_px.pix_valid, 0);
      check("solid_no_reads", mem_seen, 0);
      @(posedge clk); #1;
      check("solid_idle", {d_done, d_busy}, 0);
      run_small(0, -1, 50);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", s_px.pix_valid, 0);
      check("mid_rst_busy", s_busy, 0);
      check("mid_rst_done", s_done, 0);
      check("mid_rst_addr", s_mem_addr, 0);
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("mid_rst_no_done", s_done, 0);
      end
      run_small(0, -1, -1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
